rob_commit_reader: RTL and testbench

- In-order read/retire side of the reorder-buffer entry register bank in the out-of-order core.
- Watches the DEPTH entries held in the enable-register bank. Each entry is 33 bits: bit 32 = done flag, bits 31:0 = result payload.
- Presents the head entry to the architectural commit stage over a valid/ready handshake, then tells the bank which entry to clear.
- Tracks head pointer and occupancy; the allocating writer only pulses alloc.

---
 rtl/rob_commit_reader_if.sv | 27 ++
 rtl/rob_commit_reader.sv | 140 ++++++++++++++
 tb/tb_rob_commit_reader.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_reader_if.sv
// Commit handshake between the ROB read side and the architectural commit stage.
// Payload and index hold stable while commit_valid is high and commit_ready is low.
interface rob_commit_reader_if #(
  parameter int DEPTH  = 8,
  parameter int LENGTH = 33
);
  localparam int IW = $clog2(DEPTH);

  logic              commit_valid;
  logic              commit_ready;
  logic [LENGTH-2:0] commit_data;
  logic [IW-1:0]     commit_index;

  modport master (
    output commit_valid,
    output commit_data,
    output commit_index,
    input  commit_ready
  );

  modport slave (
    input  commit_valid,
    input  commit_data,
    input  commit_index,
    output commit_ready
  );
endinterface

// File: rtl/rob_commit_reader.sv
// In-order retire side of the reorder-buffer bank: offers the head entry once its
// done bit is set, advances head on commit and pulses a clear for the retired entry.
//
// state | meaning
// IDLE  | nothing offered; waiting for a done entry at head
// OFFER | head entry registered and presented with commit_valid high
module rob_commit_reader #(
  parameter int DEPTH  = 8,
  parameter int LENGTH = 33
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DEPTH*LENGTH-1:0]    entries_q,
  input  logic                       alloc,
  input  logic                       flush,
  rob_commit_reader_if.master        commit,
  output logic                       clear_en,
  output logic [$clog2(DEPTH)-1:0]   clear_index,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     head_q, head_d, head_nxt;
  logic [IW-1:0]     index_q, index_d;
  logic [IW-1:0]     clear_index_q, clear_index_d;
  logic [CW-1:0]     count_q, count_d;
  logic [LENGTH-2:0] data_q, data_d;
  logic              clear_en_q, clear_en_d;
  logic              overflow_q, overflow_d;
  logic [LENGTH-1:0] entry [DEPTH];
  logic [LENGTH-1:0] head_entry, next_entry;
  logic              do_commit, do_alloc;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign entry[i] = entries_q[i*LENGTH +: LENGTH];
  end

  // Only the head and the entry after it are ever inspected.
  assign head_nxt   = head_q + IW'(1);
  assign head_entry = entry[head_q];
  assign next_entry = entry[head_nxt];

  assign full  = (count_q == COUNT_MAX);
  assign empty = (count_q == '0);

  assign do_commit = (state_q == OFFER) && commit.commit_ready;
  // A commit in the same cycle frees the slot a full-bank alloc needs.
  assign do_alloc  = alloc && (!full || do_commit);

  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    count_d       = count_q;
    data_d        = data_q;
    index_d       = index_q;
    clear_en_d    = 1'b0;
    clear_index_d = clear_index_q;
    overflow_d    = overflow_q;

    if (flush) begin
      // Squash voids any same-cycle handshake and drops any alloc.
      state_d = IDLE;
      head_d  = '0;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0 && head_entry[LENGTH-1]) begin
            data_d  = head_entry[LENGTH-2:0];
            index_d = head_q;
            state_d = OFFER;
          end
        end
        OFFER: begin
          if (commit.commit_ready) begin
            head_d        = head_nxt;
            clear_en_d    = 1'b1;
            clear_index_d = index_q;
            if (count_q != COUNT_ONE && next_entry[LENGTH-1]) begin
              data_d  = next_entry[LENGTH-2:0];
              index_d = head_nxt;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      case ({do_alloc, do_commit})
        2'b10:   count_d = count_q + COUNT_ONE;
        2'b01:   count_d = count_q - COUNT_ONE;
        default: count_d = count_q;
      endcase

      if (alloc && full && !do_commit) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      head_q        <= '0;
      count_q       <= '0;
      data_q        <= '0;
      index_q       <= '0;
      clear_en_q    <= 1'b0;
      clear_index_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      count_q       <= count_d;
      data_q        <= data_d;
      index_q       <= index_d;
      clear_en_q    <= clear_en_d;
      clear_index_q <= clear_index_d;
      overflow_q    <= overflow_d;
    end
  end

  assign commit.commit_valid = (state_q == OFFER);
  assign commit.commit_data  = data_q;
  assign commit.commit_index = index_q;
  assign clear_en            = clear_en_q;
  assign clear_index         = clear_index_q;
  assign count               = count_q;
  assign overflow            = overflow_q;
endmodule

// File: tb/tb_rob_commit_reader.sv
// Directed bench for rob_commit_reader: stimulus queues expected commits and clears,
// a negedge monitor pops and compares whenever a handshake or clear pulse appears.
module tb_rob_commit_reader;
  localparam int DEPTH  = 8;
  localparam int LENGTH = 33;
  localparam int IW     = 3;
  localparam int CW     = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [DEPTH*LENGTH-1:0] entries_q;
  logic                    alloc;
  logic                    flush;
  logic                    clear_en;
  logic [IW-1:0]           clear_index;
  logic [CW-1:0]           count;
  logic                    full;
  logic                    empty;
  logic                    overflow;

  rob_commit_reader_if #(.DEPTH(DEPTH), .LENGTH(LENGTH)) cif ();

  rob_commit_reader #(.DEPTH(DEPTH), .LENGTH(LENGTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .entries_q   (entries_q),
    .alloc       (alloc),
    .flush       (flush),
    .commit      (cif),
    .clear_en    (clear_en),
    .clear_index (clear_index),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] exp_idx_q [$];
  logic [31:0]   exp_data_q [$];
  logic [IW-1:0] exp_clr_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_entry(input int i, input logic done, input logic [31:0] d);
    entries_q[i*LENGTH +: LENGTH] = {done, d};
  endtask

  task automatic expect_commit(input int i, input logic [31:0] d);
    exp_idx_q.push_back(IW'(i));
    exp_data_q.push_back(d);
    exp_clr_q.push_back(IW'(i));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_n(input int n);
    alloc = 1'b1;
    for (int k = 0; k < n; k++) cyc();
    alloc = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    cif.commit_ready = 1'b1;
    while (count != '0 && n < limit) begin
      cyc();
      n++;
    end
    cif.commit_ready = 1'b0;
    check("drain_count", 32'(count), 32'd0);
  endtask

  // Monitor: a handshake is real only when flush is low on that edge.
  logic [IW-1:0] mon_idx;
  logic [31:0]   mon_data;
  always @(negedge clk) begin
    if (reset) begin
      if (cif.commit_valid && cif.commit_ready && !flush) begin
        if (exp_idx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: got index %0d expected no commit", cif.commit_index);
        end else begin
          mon_idx  = exp_idx_q.pop_front();
          mon_data = exp_data_q.pop_front();
          check("commit_index", 32'(cif.commit_index), 32'(mon_idx));
          check("commit_data", cif.commit_data, mon_data);
        end
      end
      if (clear_en) begin
        if (exp_clr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_clear: got index %0d expected no clear", clear_index);
        end else begin
          mon_idx = exp_clr_q.pop_front();
          check("clear_index", 32'(clear_index), 32'(mon_idx));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b0;
    entries_q        = '0;
    alloc            = 1'b0;
    flush            = 1'b0;
    cif.commit_ready = 1'b0;

    #12;
    check("rst_valid", 32'(cif.commit_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_clear_en", 32'(clear_en), 32'd0);
    reset = 1'b1;
    cyc();

    // Single entry, 1-cycle offer latency, then clear pulse.
    alloc_n(1);
    set_entry(0, 1'b1, 32'hDEAD_BEEF);
    expect_commit(0, 32'hDEAD_BEEF);
    cyc();
    check("t1_valid", 32'(cif.commit_valid), 32'd1);
    check("t1_index", 32'(cif.commit_index), 32'd0);
    cif.commit_ready = 1'b1;
    cyc();
    cif.commit_ready = 1'b0;
    check("t1_clear_en", 32'(clear_en), 32'd1);
    check("t1_clear_index", 32'(clear_index), 32'd0);
    check("t1_count", 32'(count), 32'd0);
    check("t1_empty", 32'(empty), 32'd1);
    set_entry(0, 1'b0, 32'h0);

    // Stall for 4 cycles, then three back-to-back commits (head starts at 1).
    alloc_n(3);
    check("t2_count", 32'(count), 32'd3);
    set_entry(1, 1'b1, 32'hA000_0001);
    set_entry(2, 1'b1, 32'hA000_0002);
    set_entry(3, 1'b1, 32'hA000_0003);
    expect_commit(1, 32'hA000_0001);
    expect_commit(2, 32'hA000_0002);
    expect_commit(3, 32'hA000_0003);
    cyc();
    for (int k = 0; k < 4; k++) begin
      check("t2_hold_valid", 32'(cif.commit_valid), 32'd1);
      check("t2_hold_index", 32'(cif.commit_index), 32'd1);
      check("t2_hold_data", cif.commit_data, 32'hA000_0001);
      cyc();
    end
    cif.commit_ready = 1'b1;
    cyc();
    check("t2_count_a", 32'(count), 32'd2);
    cyc();
    check("t2_count_b", 32'(count), 32'd1);
    cyc();
    check("t2_count_c", 32'(count), 32'd0);
    cif.commit_ready = 1'b0;
    check("t2_valid_off", 32'(cif.commit_valid), 32'd0);
    for (int i = 1; i <= 3; i++) set_entry(i, 1'b0, 32'h0);

    // Advance head to 6, then wrap: 6,7,0,1.
    alloc_n(2);
    set_entry(4, 1'b1, 32'hB000_0004);
    set_entry(5, 1'b1, 32'hB000_0005);
    expect_commit(4, 32'hB000_0004);
    expect_commit(5, 32'hB000_0005);
    drain(20);
    set_entry(4, 1'b0, 32'h0);
    set_entry(5, 1'b0, 32'h0);
    alloc_n(4);
    check("t3_count", 32'(count), 32'd4);
    set_entry(6, 1'b1, 32'hC000_0006);
    set_entry(7, 1'b1, 32'hC000_0007);
    set_entry(0, 1'b1, 32'hC000_0000);
    set_entry(1, 1'b1, 32'hC000_0001);
    expect_commit(6, 32'hC000_0006);
    expect_commit(7, 32'hC000_0007);
    expect_commit(0, 32'hC000_0000);
    expect_commit(1, 32'hC000_0001);
    drain(20);
    for (int i = 0; i < DEPTH; i++) set_entry(i, 1'b0, 32'h0);

    // Fill (head = 2), overflow, alloc+commit while full.
    alloc_n(8);
    check("t4_count_full", 32'(count), 32'd8);
    check("t4_full", 32'(full), 32'd1);
    check("t4_empty", 32'(empty), 32'd0);
    check("t4_overflow_pre", 32'(overflow), 32'd0);
    alloc_n(1);
    check("t4_count_ovf", 32'(count), 32'd8);
    check("t4_overflow", 32'(overflow), 32'd1);
    set_entry(2, 1'b1, 32'hD000_0002);
    expect_commit(2, 32'hD000_0002);
    cyc();
    check("t4_valid", 32'(cif.commit_valid), 32'd1);
    cif.commit_ready = 1'b1;
    alloc = 1'b1;
    cyc();
    cif.commit_ready = 1'b0;
    alloc = 1'b0;
    check("t4_count_swap", 32'(count), 32'd8);
    check("t4_full_swap", 32'(full), 32'd1);
    set_entry(2, 1'b0, 32'h0);

    // Down to 5 entries (head = 6), then flush during a live handshake.
    set_entry(3, 1'b1, 32'hE000_0003);
    set_entry(4, 1'b1, 32'hE000_0004);
    set_entry(5, 1'b1, 32'hE000_0005);
    expect_commit(3, 32'hE000_0003);
    expect_commit(4, 32'hE000_0004);
    expect_commit(5, 32'hE000_0005);
    cif.commit_ready = 1'b1;
    for (int n = 0; n < 10 && count != CW'(5); n++) cyc();
    cif.commit_ready = 1'b0;
    check("t5_count5", 32'(count), 32'd5);
    for (int i = 3; i <= 5; i++) set_entry(i, 1'b0, 32'h0);
    set_entry(6, 1'b1, 32'h0000_0BAD);
    cyc();
    check("t5_valid", 32'(cif.commit_valid), 32'd1);
    check("t5_index", 32'(cif.commit_index), 32'd6);
    flush = 1'b1;
    cif.commit_ready = 1'b1;
    cyc();
    flush = 1'b0;
    cif.commit_ready = 1'b0;
    check("t5_count", 32'(count), 32'd0);
    check("t5_valid_off", 32'(cif.commit_valid), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_no_clear", 32'(clear_en), 32'd0);
    set_entry(6, 1'b0, 32'h0);

    // Head returned to 0 after flush.
    alloc_n(1);
    set_entry(0, 1'b1, 32'h5555_AAAA);
    expect_commit(0, 32'h5555_AAAA);
    drain(10);
    set_entry(0, 1'b0, 32'h0);

    // Asynchronous reset in the middle of an offer.
    alloc_n(2);
    set_entry(1, 1'b1, 32'hF000_0001);
    cyc();
    check("t6_valid", 32'(cif.commit_valid), 32'd1);
    check("t6_overflow_sticky", 32'(overflow), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_valid_async", 32'(cif.commit_valid), 32'd0);
    check("t6_count_async", 32'(count), 32'd0);
    check("t6_overflow_async", 32'(overflow), 32'd0);
    check("t6_empty_async", 32'(empty), 32'd1);
    set_entry(1, 1'b0, 32'h0);
    cyc();
    reset = 1'b1;
    cyc();
    cyc();

    check("pending_commits", 32'(exp_idx_q.size()), 32'd0);
    check("pending_clears", 32'(exp_clr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
